// File: rtl/eq8_pkg.sv
// rtl/eq8_pkg.sv - shared widths, band indices and fixed FIR coefficient table for the 8-band equalizer
package eq8_pkg;

    localparam int FILTER_IN_BITS    = 16;
    localparam int FILTER_OUT_BITS   = 16;
    localparam int NUMBER_OF_FILTERS = 8;
    localparam int GAIN_BITS         = 8;
    localparam int GAIN_FRAC_BITS    = 2;

    localparam int TAPS           = 64;
    localparam int PHASE_BITS     = 6;
    localparam int COEFF_BITS     = 16;
    localparam int PROD_BITS      = 32;
    localparam int ACC_BITS       = 40;
    localparam int ACC_SHIFT      = 15;
    localparam int GAIN_PROD_BITS = 24;
    localparam int SUM_BITS       = 27;

    localparam logic [PHASE_BITS-1:0] LAST_PHASE = PHASE_BITS'(TAPS - 1);
    localparam logic signed [GAIN_BITS-1:0] UNITY_GAIN = GAIN_BITS'(1 << GAIN_FRAC_BITS);

    localparam logic signed [ACC_BITS-1:0] OUT_MAX = ACC_BITS'(32767);
    localparam logic signed [ACC_BITS-1:0] OUT_MIN = -ACC_BITS'(32768);

    typedef enum logic [2:0] {
        LPF1K, BPF1K2K, BPF2K3K, BPF3K4K, BPF4K5K, BPF5K6K, BPF6K7K, HPF7K
    } band_e;

    typedef logic [NUMBER_OF_FILTERS-1:0][TAPS-1:0][COEFF_BITS-1:0] coeff_tab_t;

    // Clamp a wide signed value into the 16-bit output range.
    function automatic logic signed [FILTER_OUT_BITS-1:0] sat_out(input logic signed [ACC_BITS-1:0] v);
        if (v > OUT_MAX)
            return 16'sh7fff;
        else if (v < OUT_MIN)
            return 16'sh8000;
        else
            return FILTER_OUT_BITS'(v);
    endfunction

    // sin(pi*j/16) in Q15 for the first quadrant, j = 0..8.
    function automatic int sin_quarter(input int j);
        case (j)
            0:       return 0;
            1:       return 6393;
            2:       return 12540;
            3:       return 18205;
            4:       return 23170;
            5:       return 27246;
            6:       return 30274;
            7:       return 32138;
            default: return 32767;
        endcase
    endfunction

    // sin(pi*k/16) in Q15 for any integer k, folded from the quarter table.
    function automatic int sin_q15(input int k);
        int j;
        j = ((k % 32) + 32) % 32;
        if (j <= 8)       return sin_quarter(j);
        else if (j <= 16) return sin_quarter(16 - j);
        else if (j <= 24) return -sin_quarter(j - 16);
        else              return -sin_quarter(32 - j);
    endfunction

    // Band b is lowpass((b+1) kHz) minus lowpass(b kHz): triangular-windowed
    // sinc centred at tap 31.5. With u2 = 2n-63 (always odd) the sinc argument
    // is pi*b*u2/16, so every sample lands on the 32-step sine table and the
    // half-integer centre never divides by zero. 10430/32768 approximates 1/pi.
    function automatic coeff_tab_t gen_coeff();
        coeff_tab_t tab;
        longint     num;
        longint     den;
        int         u2;
        int         w;
        tab = '0;
        for (int b = 0; b < NUMBER_OF_FILTERS; b++) begin
            for (int n = 0; n < TAPS; n++) begin
                u2  = 2 * n - (TAPS - 1);
                w   = TAPS - ((u2 < 0) ? -u2 : u2);
                num = longint'(w) * longint'(sin_q15((b + 1) * u2) - sin_q15(b * u2)) * 2 * 10430;
                den = longint'(TAPS) * longint'(u2) * 32768;
                tab[b][n] = COEFF_BITS'(num / den);
            end
        end
        return tab;
    endfunction

    localparam coeff_tab_t COEFF = gen_coeff();

endpackage

// File: rtl/eq8_amplifier.sv
// rtl/eq8_amplifier.sv - per-band gain, unity bypass, 8-way sum and output saturation
module eq8_amplifier
    import eq8_pkg::*;
(
    input  logic                                            amplifier_enable,
    input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0]          amplifier_gains,
    input  logic [NUMBER_OF_FILTERS-1:0][FILTER_OUT_BITS-1:0] bands,
    output logic signed [FILTER_OUT_BITS-1:0]               sum_out
);

    logic signed [GAIN_BITS-1:0]      gain;
    logic signed [GAIN_PROD_BITS-1:0] prod;
    logic signed [SUM_BITS-1:0]       sum;

    // Scale each band by its Q6.2 gain (floor), accumulate, then clamp once.
    always_comb begin
        gain = '0;
        prod = '0;
        sum  = '0;
        for (int b = 0; b < NUMBER_OF_FILTERS; b++) begin
            gain = amplifier_enable ? $signed(amplifier_gains[b*GAIN_BITS +: GAIN_BITS]) : UNITY_GAIN;
            prod = GAIN_PROD_BITS'($signed(bands[b])) * GAIN_PROD_BITS'(gain);
            sum  = sum + SUM_BITS'(prod >>> GAIN_FRAC_BITS);
        end
        sum_out = sat_out(ACC_BITS'(sum));
    end

endmodule

// File: rtl/eq8_filter.sv
// rtl/eq8_filter.sv - time-multiplexed 8-band 64-tap FIR equalizer core
module eq8_filter
    import eq8_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clk_enable,
    input  logic                                   amplifier_enable,
    input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
    input  logic signed [FILTER_IN_BITS-1:0]       filter_in,
    output logic signed [FILTER_OUT_BITS-1:0]      filter_out,
    output logic signed [FILTER_OUT_BITS-1:0]      filter_lpf_1000hz,
    output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_1000_2000hz,
    output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_2000_3000hz,
    output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_3000_4000hz,
    output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_4000_5000hz,
    output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_5000_6000hz,
    output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_6000_7000hz,
    output logic signed [FILTER_OUT_BITS-1:0]      filter_hpf_7000hz
);

    logic [PHASE_BITS-1:0]                              phase;
    logic signed [FILTER_IN_BITS-1:0]                   delay [TAPS];
    logic signed [ACC_BITS-1:0]                         acc [NUMBER_OF_FILTERS];
    logic signed [ACC_BITS-1:0]                         acc_next [NUMBER_OF_FILTERS];
    logic [NUMBER_OF_FILTERS-1:0][FILTER_OUT_BITS-1:0]  band_next;
    logic [NUMBER_OF_FILTERS-1:0][FILTER_OUT_BITS-1:0]  band_q;
    logic signed [FILTER_IN_BITS-1:0]                   tap;
    logic signed [COEFF_BITS-1:0]                       coef;
    logic signed [PROD_BITS-1:0]                        prod;
    logic signed [FILTER_OUT_BITS-1:0]                  amp_out;

    // Phase 0 multiplies the live input (it is only written into the delay
    // line on this same edge); later phases read back stored history x[n-k].
    always_comb begin
        tap = (phase == '0) ? filter_in : delay[phase];
    end

    // One shared tap feeds all eight MACs; phase 0 restarts the accumulators
    // and the final-phase sum is also what gets rounded into the band outputs.
    always_comb begin
        coef = '0;
        prod = '0;
        for (int b = 0; b < NUMBER_OF_FILTERS; b++) begin
            coef         = $signed(COEFF[b][phase]);
            prod         = PROD_BITS'(tap) * PROD_BITS'(coef);
            acc_next[b]  = ((phase == '0) ? '0 : acc[b]) + ACC_BITS'(prod);
            band_next[b] = sat_out(acc_next[b] >>> ACC_SHIFT);
        end
    end

    eq8_amplifier u_amplifier (
        .amplifier_enable (amplifier_enable),
        .amplifier_gains  (amplifier_gains),
        .bands            (band_next),
        .sum_out          (amp_out)
    );

    // Phase counter, delay line and accumulators advance only on enabled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            for (int i = 0; i < TAPS; i++)
                delay[i] <= '0;
            for (int b = 0; b < NUMBER_OF_FILTERS; b++)
                acc[b] <= '0;
        end else if (clk_enable) begin
            phase <= phase + PHASE_BITS'(1);
            if (phase == '0) begin
                delay[0] <= filter_in;
                for (int i = 1; i < TAPS; i++)
                    delay[i] <= delay[i-1];
            end
            for (int b = 0; b < NUMBER_OF_FILTERS; b++)
                acc[b] <= acc_next[b];
        end
    end

    // Band and mixed outputs load on the last tap edge and hold for a full sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band_q     <= '0;
            filter_out <= '0;
        end else if (clk_enable && phase == LAST_PHASE) begin
            band_q     <= band_next;
            filter_out <= amp_out;
        end
    end

    assign filter_lpf_1000hz      = band_q[LPF1K];
    assign filter_bpf_1000_2000hz = band_q[BPF1K2K];
    assign filter_bpf_2000_3000hz = band_q[BPF2K3K];
    assign filter_bpf_3000_4000hz = band_q[BPF3K4K];
    assign filter_bpf_4000_5000hz = band_q[BPF4K5K];
    assign filter_bpf_5000_6000hz = band_q[BPF5K6K];
    assign filter_bpf_6000_7000hz = band_q[BPF6K7K];
    assign filter_hpf_7000hz      = band_q[HPF7K];

endmodule

// File: tb/tb_eq8_filter.sv
// tb/tb_eq8_filter.sv - randomized self-checking bench for eq8_filter against a convolution model
module tb_eq8_filter;
    import eq8_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_enable;
    logic               amplifier_enable;
    logic [63:0]        amplifier_gains;
    logic signed [15:0] filter_in;
    logic signed [15:0] filter_out;
    logic signed [15:0] band_out [8];

    int n_tests = 0;
    int n_fail  = 0;
    int hist [64];
    int last_out = 0;

    always #5 clk = ~clk;

    eq8_filter dut (
        .clk                    (clk),
        .rst                    (rst),
        .clk_enable             (clk_enable),
        .amplifier_enable       (amplifier_enable),
        .amplifier_gains        (amplifier_gains),
        .filter_in              (filter_in),
        .filter_out             (filter_out),
        .filter_lpf_1000hz      (band_out[0]),
        .filter_bpf_1000_2000hz (band_out[1]),
        .filter_bpf_2000_3000hz (band_out[2]),
        .filter_bpf_3000_4000hz (band_out[3]),
        .filter_bpf_4000_5000hz (band_out[4]),
        .filter_bpf_5000_6000hz (band_out[5]),
        .filter_bpf_6000_7000hz (band_out[6]),
        .filter_hpf_7000hz      (band_out[7])
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Direct-form convolution over the last 64 inputs, newest at hist[0].
    function automatic int model_band(input int b);
        longint acc = 0;
        for (int k = 0; k < 64; k++)
            acc += longint'(hist[k]) * longint'($signed(COEFF[b][k]));
        return sat16(acc >>> 15);
    endfunction

    function automatic int model_out(input int bands [8]);
        longint sum = 0;
        int g;
        for (int b = 0; b < 8; b++) begin
            g = amplifier_enable ? int'($signed(amplifier_gains[b*8 +: 8])) : 4;
            sum += (longint'(bands[b]) * longint'(g)) >>> 2;
        end
        return sat16(sum);
    endfunction

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 64; k++) hist[k] = 0;
        last_out = 0;
    endtask

    // Feed one sample across 64 enabled edges, optionally stalling 5 cycles
    // after edge stall_at, then compare every output with the model.
    task automatic run_sample(input logic signed [15:0] x, input int stall_at, input string tag);
        int exp_band [8];
        int exp_out;
        filter_in  = x;
        clk_enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            edge_step();
            if (i == 0) filter_in = 16'($urandom);
            if (i == stall_at) begin
                clk_enable = 1'b0;
                repeat (5) edge_step();
                check({tag, "_stall_phase"}, dut.phase, (i + 1) % 64);
                check({tag, "_stall_hold"}, filter_out, last_out);
                clk_enable = 1'b1;
            end
        end
        for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(x);
        for (int b = 0; b < 8; b++) begin
            exp_band[b] = model_band(b);
            check($sformatf("%s_band%0d", tag, b), band_out[b], exp_band[b]);
        end
        exp_out = model_out(exp_band);
        check({tag, "_out"}, filter_out, exp_out);
        last_out = exp_out;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, filter_out, 0);
        for (int b = 0; b < 8; b++)
            check($sformatf("%s_band%0d", tag, b), band_out[b], 0);
        check({tag, "_phase"}, dut.phase, 0);
    endtask

    initial begin
        int coef_half;
        logic [63:0] gains_ramp;
        rst              = 1'b1;
        clk_enable       = 1'b1;
        amplifier_enable = 1'b0;
        amplifier_gains  = '0;
        filter_in        = 16'sh1234;
        clear_model();

        repeat (10) edge_step();
        check_all_zero("reset");

        rst        = 1'b0;
        clk_enable = 1'b0;
        repeat (10) edge_step();
        check_all_zero("frozen");

        // Impulse at half scale with unity gain: band output m is COEFF[m]>>>1.
        for (int m = 0; m <= 64; m++) begin
            run_sample((m == 0) ? 16'sh4000 : 16'sh0000, -1, "imp");
            for (int b = 0; b < 8; b++) begin
                coef_half = (m < 64) ? (int'($signed(COEFF[b][m])) >>> 1) : 0;
                check($sformatf("imp_coef_b%0d_m%0d", b, m), band_out[b], coef_half);
            end
        end

        // Same impulse with gains 0.25 .. 2.0 on bands 0 .. 7.
        for (int b = 0; b < 8; b++) gains_ramp[b*8 +: 8] = 8'(b + 1);
        amplifier_gains  = gains_ramp;
        amplifier_enable = 1'b1;
        for (int m = 0; m <= 64; m++)
            run_sample((m == 0) ? 16'sh4000 : 16'sh0000, -1, "gain_imp");

        // Random audio, random gains / bypass, occasional 5-cycle stalls.
        for (int s = 0; s < 60; s++) begin
            if (s % 8 == 0) begin
                amplifier_gains  = {$urandom, $urandom};
                amplifier_enable = 1'($urandom_range(0, 1));
            end
            run_sample(16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 62)) : -1, "rand");
        end

        // Full-scale DC with maximum gain must clamp, not wrap.
        amplifier_enable = 1'b1;
        amplifier_gains  = {8{8'h7f}};
        for (int s = 0; s < 64; s++) run_sample(16'sh7fff, -1, "dc_pos");
        check("dc_pos_sat", filter_out, 32767);
        for (int s = 0; s < 64; s++) run_sample(16'sh8000, -1, "dc_neg");
        check("dc_neg_sat", filter_out, -32768);

        // Reset landing mid-sample aborts it; processing restarts from phase 0.
        amplifier_gains  = {$urandom, $urandom};
        for (int s = 0; s < 4; s++) run_sample(16'($urandom), -1, "pre_rst");
        filter_in  = 16'sh2000;
        clk_enable = 1'b1;
        repeat (30) edge_step();
        check("pre_rst_phase", dut.phase, 30);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        edge_step();
        edge_step();
        rst = 1'b0;
        clear_model();
        for (int s = 0; s < 6; s++) run_sample(16'($urandom), -1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
